// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC parallel-bus machines: state encoding,
// default phase timing, bus idle levels and RTC register addresses.
package rtc_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_DIR   = 4'd1,
    ST_LAT_A = 4'd2,
    ST_A_SU  = 4'd3,
    ST_A_PW  = 4'd4,
    ST_A_H   = 4'd5,
    ST_REC   = 4'd6,
    ST_D_SU  = 4'd7,
    ST_D_PW  = 4'd8,
    ST_D_H   = 4'd9,
    ST_DAT   = 4'd10,
    ST_FIN   = 4'd11
  } state_e;

  localparam int unsigned T_SU_DEF  = 2;
  localparam int unsigned T_PW_DEF  = 4;
  localparam int unsigned T_H_DEF   = 2;
  localparam int unsigned T_REC_DEF = 3;

  localparam logic       CS_N_IDLE  = 1'b1;
  localparam logic       RD_N_IDLE  = 1'b1;
  localparam logic       WR_N_IDLE  = 1'b1;
  localparam logic       AD_N_IDLE  = 1'b1;
  localparam logic       AD_OE_IDLE = 1'b0;
  localparam logic [7:0] AD_IDLE    = 8'h00;

  localparam logic [7:0] RTC_CMD_XFER_A = 8'hF1;
  localparam logic [7:0] RTC_CMD_XFER_B = 8'hF2;
  localparam logic [7:0] RTC_ADDR_SEC   = 8'h21;
  localparam logic [7:0] RTC_ADDR_MIN   = 8'h22;
  localparam logic [7:0] RTC_ADDR_HOUR  = 8'h23;
  localparam logic [7:0] RTC_ADDR_DAY   = 8'h24;
  localparam logic [7:0] RTC_ADDR_MON   = 8'h25;
  localparam logic [7:0] RTC_ADDR_YEAR  = 8'h26;

  // Cycles-minus-one spent in a state; untimed states last a single cycle.
  function automatic logic [3:0] phase_len_m1(input state_e st,
                                              input logic [3:0] su_m1,
                                              input logic [3:0] pw_m1,
                                              input logic [3:0] h_m1,
                                              input logic [3:0] rec_m1);
    logic [3:0] len;
    case (st)
      ST_A_SU, ST_D_SU: len = su_m1;
      ST_A_PW, ST_D_PW: len = pw_m1;
      ST_A_H,  ST_D_H:  len = h_m1;
      ST_REC:           len = rec_m1;
      default:          len = 4'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable 4-bit down-counter; zero_o flags the final cycle of a phase.
module phase_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  output logic       zero_o
);

  logic [3:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= 4'd0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/rtc_bus_timing.sv
// Bus-cycle generator for the RTC multiplexed address/data bus: one address
// phase and one data phase per request, with DIR/DAT/cambio_estado handshakes.
module rtc_bus_timing
  import rtc_pkg::*;
#(
  parameter int unsigned T_SU  = T_SU_DEF,
  parameter int unsigned T_PW  = T_PW_DEF,
  parameter int unsigned T_H   = T_H_DEF,
  parameter int unsigned T_REC = T_REC_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       rw,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic       DIR,
  output logic       DAT,
  output logic       cambio_estado,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       ad_n,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in
);

  localparam logic [3:0] SU_M1  = 4'(T_SU - 1);
  localparam logic [3:0] PW_M1  = 4'(T_PW - 1);
  localparam logic [3:0] H_M1   = 4'(T_H - 1);
  localparam logic [3:0] REC_M1 = 4'(T_REC - 1);

  state_e     state_q, state_d;
  logic       armed_q, armed_d;
  logic       rw_q;
  logic       start_s;
  logic       zero_s;
  logic       load_s;
  logic [3:0] load_val_s;

  logic       dir_q, dat_q, fin_q, busy_q;
  logic       cs_n_q, rd_n_q, wr_n_q, ad_n_q, ad_oe_q;
  logic [7:0] ad_out_q, rdata_q;

  assign start_s    = (state_q == ST_IDLE) && en && armed_q;
  assign load_s     = (state_d != state_q);
  assign load_val_s = phase_len_m1(state_d, SU_M1, PW_M1, H_M1, REC_M1);

  phase_timer u_phase_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load_s),
    .load_val_i (load_val_s),
    .zero_o     (zero_s)
  );

  // Next-state and re-arm logic; en only matters in IDLE.
  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          state_d = ST_DIR;
          armed_d = 1'b0;
        end else if (!en) begin
          armed_d = 1'b1;
        end else begin
          armed_d = armed_q;
        end
      end
      ST_DIR:   state_d = ST_LAT_A;
      ST_LAT_A: state_d = ST_A_SU;
      ST_A_SU:  if (zero_s) state_d = ST_A_PW; else state_d = state_q;
      ST_A_PW:  if (zero_s) state_d = ST_A_H;  else state_d = state_q;
      ST_A_H:   if (zero_s) state_d = ST_REC;  else state_d = state_q;
      ST_REC:   if (zero_s) state_d = ST_D_SU; else state_d = state_q;
      ST_D_SU:  if (zero_s) state_d = ST_D_PW; else state_d = state_q;
      ST_D_PW:  if (zero_s) state_d = ST_D_H;  else state_d = state_q;
      ST_D_H:   if (zero_s) state_d = ST_DAT;  else state_d = state_q;
      ST_DAT:   state_d = ST_FIN;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, arm flag and latched direction.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      armed_q <= 1'b1;
      rw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      rw_q    <= start_s ? rw : rw_q;
    end
  end

  // Pins are decoded from the next state so they switch on state boundaries.
  always_ff @(posedge clk) begin
    if (!reset) begin
      dir_q    <= 1'b0;
      dat_q    <= 1'b0;
      fin_q    <= 1'b0;
      busy_q   <= 1'b0;
      cs_n_q   <= CS_N_IDLE;
      rd_n_q   <= RD_N_IDLE;
      wr_n_q   <= WR_N_IDLE;
      ad_n_q   <= AD_N_IDLE;
      ad_oe_q  <= AD_OE_IDLE;
      ad_out_q <= AD_IDLE;
      rdata_q  <= 8'h00;
    end else begin
      dir_q   <= (state_d == ST_DIR);
      dat_q   <= (state_d == ST_DAT);
      fin_q   <= (state_d == ST_FIN);
      busy_q  <= (state_d != ST_IDLE);
      cs_n_q  <= !(state_d inside {[ST_LAT_A:ST_D_H]});
      ad_n_q  <= !(state_d inside {[ST_A_SU:ST_A_H]});
      ad_oe_q <= (state_d inside {[ST_A_SU:ST_A_H]}) ||
                 (!rw_q && (state_d inside {[ST_D_SU:ST_D_H]}));
      // Address-phase strobe uses wr_n; the data-phase strobe follows direction.
      wr_n_q  <= !((state_d == ST_A_PW) || (!rw_q && (state_d == ST_D_PW)));
      rd_n_q  <= !(rw_q && (state_d == ST_D_PW));

      if ((state_q == ST_LAT_A) && (state_d == ST_A_SU)) begin
        ad_out_q <= addr;
      end else if (!rw_q && (state_q == ST_A_H) && (state_d == ST_REC)) begin
        ad_out_q <= wdata;
      end else begin
        ad_out_q <= ad_out_q;
      end

      if (rw_q && (state_q == ST_D_PW) && zero_s) begin
        rdata_q <= ad_in;
      end else begin
        rdata_q <= rdata_q;
      end
    end
  end

  assign DIR           = dir_q;
  assign DAT           = dat_q;
  assign cambio_estado = fin_q;
  assign busy          = busy_q;
  assign cs_n          = cs_n_q;
  assign rd_n          = rd_n_q;
  assign wr_n          = wr_n_q;
  assign ad_n          = ad_n_q;
  assign ad_oe         = ad_oe_q;
  assign ad_out        = ad_out_q;
  assign rdata         = rdata_q;

endmodule

// File: tb/tb_rtc_bus_timing.sv
// Directed bench for rtc_bus_timing: default-timing and all-ones-timing
// instances, an RTC register model on the bus and a read-data scoreboard.
module tb_rtc_bus_timing;
  import rtc_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, en, rw, sel;
  logic [7:0] addr, wdata;
  logic [7:0] mem [256];

  logic       d_dir, d_dat, d_fin, d_busy, d_cs_n, d_rd_n, d_wr_n, d_ad_n, d_ad_oe;
  logic [7:0] d_rdata, d_ad_out, d_ad_in, d_la;
  logic       f_dir, f_dat, f_fin, f_busy, f_cs_n, f_rd_n, f_wr_n, f_ad_n, f_ad_oe;
  logic [7:0] f_rdata, f_ad_out, f_ad_in, f_la;
  logic       en_d, en_f;

  assign en_d = en & ~sel;
  assign en_f = en & sel;

  rtc_bus_timing dut (
    .clk(clk), .reset(reset), .en(en_d), .rw(rw), .addr(addr), .wdata(wdata),
    .DIR(d_dir), .DAT(d_dat), .cambio_estado(d_fin), .rdata(d_rdata), .busy(d_busy),
    .cs_n(d_cs_n), .rd_n(d_rd_n), .wr_n(d_wr_n), .ad_n(d_ad_n),
    .ad_out(d_ad_out), .ad_oe(d_ad_oe), .ad_in(d_ad_in)
  );

  rtc_bus_timing #(.T_SU(1), .T_PW(1), .T_H(1), .T_REC(1)) dut_fast (
    .clk(clk), .reset(reset), .en(en_f), .rw(rw), .addr(addr), .wdata(wdata),
    .DIR(f_dir), .DAT(f_dat), .cambio_estado(f_fin), .rdata(f_rdata), .busy(f_busy),
    .cs_n(f_cs_n), .rd_n(f_rd_n), .wr_n(f_wr_n), .ad_n(f_ad_n),
    .ad_out(f_ad_out), .ad_oe(f_ad_oe), .ad_in(f_ad_in)
  );

  // RTC model: address latched on the address strobe, register driven while rd_n is low.
  always @(posedge clk) if (!d_ad_n && !d_wr_n) d_la <= d_ad_out;
  always @(posedge clk) if (!f_ad_n && !f_wr_n) f_la <= f_ad_out;
  assign d_ad_in = !d_rd_n ? mem[d_la] : 8'h00;
  assign f_ad_in = !f_rd_n ? mem[f_la] : 8'h00;

  logic       o_dir, o_dat, o_fin, o_busy, o_cs_n, o_rd_n, o_wr_n, o_ad_n, o_ad_oe;
  logic [7:0] o_rdata, o_ad_out;
  assign o_dir    = sel ? f_dir    : d_dir;
  assign o_dat    = sel ? f_dat    : d_dat;
  assign o_fin    = sel ? f_fin    : d_fin;
  assign o_busy   = sel ? f_busy   : d_busy;
  assign o_cs_n   = sel ? f_cs_n   : d_cs_n;
  assign o_rd_n   = sel ? f_rd_n   : d_rd_n;
  assign o_wr_n   = sel ? f_wr_n   : d_wr_n;
  assign o_ad_n   = sel ? f_ad_n   : d_ad_n;
  assign o_ad_oe  = sel ? f_ad_oe  : d_ad_oe;
  assign o_rdata  = sel ? f_rdata  : d_rdata;
  assign o_ad_out = sel ? f_ad_out : d_ad_out;

  int         n_cmp = 0;
  int         n_mis = 0;
  logic [7:0] sb_q [$];
  logic [7:0] last_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rng(input int lo, input int hi);
    logic [31:0] m;
    m = 32'h0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // One request: en raised in cycle 0, 32 cycles observed as per-cycle bit masks.
  task automatic txn(input bit s, input bit r, input logic [7:0] a, input logic [7:0] w,
                     input bit hold, input int rst_at);
    int su, pw, h, rec, aend, dsu, dpw, dend, dt;
    logic [31:0] keep;
    logic [31:0] m_dir, m_dat, m_fin, m_busy, m_cs, m_adn, m_oe, m_wr, m_rd, m_both, m_aa, m_wd;
    su = s ? 1 : 2; pw = s ? 1 : 4; h = s ? 1 : 2; rec = s ? 1 : 3;
    aend = 3 + su + pw + h - 1;
    dsu  = aend + 1 + rec;
    dpw  = dsu + su;
    dend = dpw + pw + h - 1;
    dt   = dend + 1;
    keep = (rst_at >= 0) ? rng(0, rst_at) : 32'hFFFF_FFFF;
    {m_dir, m_dat, m_fin, m_busy, m_cs, m_adn} = {6{32'h0}};
    {m_oe, m_wr, m_rd, m_both, m_aa, m_wd} = {6{32'h0}};
    sel = s; rw = r; addr = a; wdata = w; en = 1'b1;
    if (r && rst_at < 0) sb_q.push_back(mem[a]);
    for (int c = 0; c < 32; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        if (!hold) en = 1'b0;
        if (rst_at >= 0 && c == rst_at + 1) reset = 1'b1;
      end
      m_dir[c]  = o_dir;   m_dat[c] = o_dat;   m_fin[c] = o_fin;  m_busy[c] = o_busy;
      m_cs[c]   = !o_cs_n; m_adn[c] = !o_ad_n; m_oe[c]  = o_ad_oe;
      m_wr[c]   = !o_wr_n; m_rd[c]  = !o_rd_n; m_both[c] = !o_wr_n && !o_rd_n;
      m_aa[c]   = (o_ad_out == a); m_wd[c] = (o_ad_out == w);
      if (o_dat && sb_q.size() > 0) chk("rdata@DAT", {24'h0, o_rdata}, {24'h0, sb_q.pop_front()});
      if (c == rst_at) reset = 1'b0;
    end
    chk("DIR",      m_dir,  rng(1, 1) & keep);
    chk("DAT",      m_dat,  rng(dt, dt) & keep);
    chk("cambio",   m_fin,  rng(dt + 1, dt + 1) & keep);
    chk("busy",     m_busy, rng(1, dt + 1) & keep);
    chk("cs_low",   m_cs,   rng(2, dend) & keep);
    chk("ad_n_low", m_adn,  rng(3, aend) & keep);
    chk("ad_oe",    m_oe,   (rng(3, aend) | (r ? 32'h0 : rng(dsu, dend))) & keep);
    chk("wr_low",   m_wr,   (rng(3 + su, 3 + su + pw - 1) | (r ? 32'h0 : rng(dpw, dpw + pw - 1))) & keep);
    chk("rd_low",   m_rd,   (r ? rng(dpw, dpw + pw - 1) : 32'h0) & keep);
    chk("rd_wr_both", m_both, 32'h0);
    if (rst_at < 0) chk("ad_out_addr", m_aa & rng(3, aend), rng(3, aend));
    if (!r) chk("ad_out_wdata", m_wd & rng(dpw, dpw + pw - 1), rng(dpw, dpw + pw - 1));
    if (!s) begin
      if (r) last_rd = (rst_at >= 0) ? 8'h00 : mem[a];
      chk("rdata_hold", {24'h0, d_rdata}, {24'h0, last_rd});
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[RTC_ADDR_SEC]  = 8'h45;
    mem[RTC_ADDR_MIN]  = 8'h30;
    mem[RTC_ADDR_HOUR] = 8'h12;
    mem[RTC_ADDR_DAY]  = 8'h15;
    mem[RTC_ADDR_MON]  = 8'h06;
    mem[RTC_ADDR_YEAR] = 8'h24;
    reset = 1'b0; en = 1'b0; rw = 1'b0; sel = 1'b0; addr = 8'h00; wdata = 8'h00;
    last_rd = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pins", {27'h0, d_cs_n, d_rd_n, d_wr_n, d_ad_n, d_ad_oe}, {27'h0, 5'b11110});
    chk("rst_strobes", {28'h0, d_dir, d_dat, d_fin, d_busy}, 32'h0);
    chk("rst_data", {16'h0, d_ad_out, d_rdata}, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;

    txn(1'b0, 1'b1, RTC_ADDR_SEC, 8'h00, 1'b0, -1);
    txn(1'b0, 1'b0, RTC_CMD_XFER_A, 8'h01, 1'b0, -1);

    txn(1'b0, 1'b1, RTC_ADDR_MIN, 8'h00, 1'b1, -1);
    @(posedge clk); #1;
    en = 1'b0;
    @(posedge clk); #1;
    txn(1'b0, 1'b1, RTC_ADDR_HOUR, 8'h00, 1'b0, -1);

    txn(1'b0, 1'b1, RTC_ADDR_DAY, 8'h00, 1'b0, 17);

    txn(1'b1, 1'b1, RTC_ADDR_MON, 8'h00, 1'b0, -1);
    txn(1'b1, 1'b0, RTC_CMD_XFER_B, 8'h5A, 1'b0, -1);

    txn(1'b0, 1'b0, RTC_CMD_XFER_A, 8'h01, 1'b0, -1);
    txn(1'b0, 1'b1, RTC_ADDR_SEC,  8'h00, 1'b0, -1);
    txn(1'b0, 1'b1, RTC_ADDR_MIN,  8'h00, 1'b0, -1);
    txn(1'b0, 1'b1, RTC_ADDR_HOUR, 8'h00, 1'b0, -1);
    txn(1'b0, 1'b1, RTC_ADDR_DAY,  8'h00, 1'b0, -1);
    txn(1'b0, 1'b1, RTC_ADDR_MON,  8'h00, 1'b0, -1);
    txn(1'b0, 1'b1, RTC_ADDR_YEAR, 8'h00, 1'b0, -1);

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
